hdmi_fb_reader: RTL

//  Framebuffer read scheduler feeding the HDMI pixel adapter's 64-bit packed-RGB stream.

---
 rtl/hdmi_fb_reader_pkg.sv | 12 +
 rtl/hdmi_fb_fifo.sv | 40 ++++
 rtl/hdmi_fb_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hdmi_fb_reader_pkg.sv
// hdmi_fb_reader_pkg: shared state encoding, beat geometry and frame-size helper for the framebuffer reader.
package hdmi_fb_reader_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;
  localparam int BYTES_PER_BEAT  = 8;
  localparam int BYTES_PER_PIXEL = 3;
  localparam int FRAME_BEATS_W   = 20;
  function automatic logic [FRAME_BEATS_W-1:0] calc_frame_beats(input logic [9:0] w, input logic [9:0] h);
    logic [21:0] prod;
    prod = 22'(w) * 22'(h) * 22'(BYTES_PER_PIXEL);
    return FRAME_BEATS_W'(prod >> $clog2(BYTES_PER_BEAT));
  endfunction
endpackage

// File: rtl/hdmi_fb_fifo.sv
// hdmi_fb_fifo: synchronous first-word-fall-through FIFO with flush and occupancy count.
module hdmi_fb_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      i_flush,
  input  logic                      i_wr_en,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic                      i_rd_en,
  output logic [WIDTH-1:0]          o_rd_data,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_full, w_wr, w_rd;
  assign o_empty   = r_cnt == '0;
  assign w_full    = r_cnt == (AW+1)'(DEPTH);
  assign w_rd      = i_rd_en && !o_empty;
  assign w_wr      = i_wr_en && (!w_full || w_rd);
  assign o_rd_data = r_mem[r_rp];
  assign o_count   = r_cnt;
  always_ff @(posedge aclk) begin
    if (areset || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge aclk)
    if (w_wr) r_mem[r_wp] <= i_wr_data;
endmodule

// File: rtl/hdmi_fb_reader.sv
// hdmi_fb_reader: AXI4 framebuffer read scheduler feeding a 64-bit packed-RGB stream, re-armed at each end of video.
// Define HDMI_FB_READER_STATS_EN to add the underrun_cnt / frame_cnt statistics outputs.
module hdmi_fb_reader
  import hdmi_fb_reader_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_OUTST  = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic [31:0] fb_base,
  input  logic [9:0]  screen_width,
  input  logic [9:0]  screen_height,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic        m_axi_rvalid,
  input  logic        m_axi_rlast,
  output logic        m_axi_rready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        busy
`ifdef HDMI_FB_READER_STATS_EN
  ,
  output logic [15:0] underrun_cnt,
  output logic [15:0] frame_cnt
`endif
);
  localparam int FW = FRAME_BEATS_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int LW = $clog2(BURST_LEN) + 1;
  state_t          r_state, w_next;
  logic [31:0]     r_base, r_araddr;
  logic [FW-1:0]   r_frame_beats, r_req_cnt, r_out_cnt, w_remain;
  logic [OW-1:0]   r_outst;
  logic [CW-1:0]   r_reserved, w_count;
  logic [7:0]      r_arlen;
  logic [LW-1:0]   w_len;
  logic            r_arvalid, w_eov, w_space_ok, w_issue, w_ar_hs, w_r_hs, w_rlast_hs;
  logic            w_fifo_wr, w_empty, w_tvalid, w_t_hs;
  logic [63:0]     w_fifo_data;
  assign w_eov      = cx == 10'd0 && cy == screen_height;
  assign w_remain   = r_frame_beats - r_req_cnt;
  assign w_len      = (w_remain >= FW'(BURST_LEN)) ? LW'(BURST_LEN) : LW'(w_remain);
  // Beats already in the FIFO plus beats promised to in-flight bursts must leave room for a full burst.
  assign w_space_ok = (CW+1)'(w_count) + (CW+1)'(r_reserved) + (CW+1)'(BURST_LEN) <= (CW+1)'(FIFO_DEPTH);
  assign w_issue    = r_state == S_RUN && !w_eov && !r_arvalid && r_req_cnt < r_frame_beats &&
                      r_outst < OW'(MAX_OUTST) && w_space_ok;
  assign w_ar_hs    = r_arvalid && m_axi_arready;
  assign w_r_hs     = m_axi_rvalid && m_axi_rready;
  assign w_rlast_hs = w_r_hs && m_axi_rlast;
  assign w_fifo_wr  = w_r_hs && r_state == S_RUN;
  assign w_tvalid   = r_state == S_RUN && !w_empty && r_out_cnt < r_frame_beats;
  assign w_t_hs     = w_tvalid && m_axis_tready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_state == S_RUN || r_state == S_DRAIN;
  assign m_axis_tdata  = w_fifo_data;
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tlast  = w_tvalid && r_out_cnt == r_frame_beats - FW'(1);
  assign busy          = r_state != S_IDLE;
  always_ff @(posedge aclk)
    r_state <= areset ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (w_eov && enable) ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   w_next = w_eov ? S_DRAIN : S_RUN;
      S_DRAIN: w_next = (r_arvalid || r_outst != '0) ? S_DRAIN : (enable ? S_LOAD : S_IDLE);
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_base        <= '0;
      r_frame_beats <= '0;
      r_req_cnt     <= '0;
      r_out_cnt     <= '0;
      r_outst       <= '0;
      r_reserved    <= '0;
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_arlen       <= '0;
    end else if (r_state == S_LOAD) begin
      r_base        <= fb_base & ~32'h7F;
      r_frame_beats <= calc_frame_beats(screen_width, screen_height);
      r_req_cnt     <= '0;
      r_out_cnt     <= '0;
      r_outst       <= '0;
      r_reserved    <= '0;
    end else begin
      if (w_issue) begin
        r_arvalid <= 1'b1;
        r_araddr  <= r_base + (32'(r_req_cnt) << $clog2(BYTES_PER_BEAT));
        r_arlen   <= 8'(w_len - LW'(1));
      end else if (w_ar_hs) r_arvalid <= 1'b0;
      if (w_ar_hs) r_req_cnt <= r_req_cnt + FW'(r_arlen) + FW'(1);
      r_outst    <= r_outst + OW'(w_ar_hs) - OW'(w_rlast_hs);
      r_reserved <= r_reserved + (w_ar_hs ? CW'(r_arlen) + CW'(1) : CW'(0)) - CW'(w_fifo_wr);
      if (w_t_hs) r_out_cnt <= r_out_cnt + FW'(1);
    end
  end
  hdmi_fb_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .i_flush   (r_state == S_DRAIN),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (m_axi_rdata),
    .i_rd_en   (w_t_hs),
    .o_rd_data (w_fifo_data),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );
`ifdef HDMI_FB_READER_STATS_EN
  logic [15:0] r_underrun, r_frame_cnt;
  logic        w_underrun;
  assign w_underrun   = r_state == S_RUN && cx < screen_width && cy < screen_height &&
                        r_out_cnt < r_frame_beats && w_empty;
  assign underrun_cnt = r_underrun;
  assign frame_cnt    = r_frame_cnt;
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_underrun  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_underrun && r_underrun != '1) r_underrun <= r_underrun + 16'd1;
      if (r_state == S_LOAD) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`endif
endmodule
